stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICK_HZ, default 100, nominal frequency of the tick input; documentation only, no effect on logic.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  one-cycle pulse from the upstream tick_timer, one per 1/100 s.
REQ-005 btn_a  input  1  start/stop command, one-cycle pulse (already debounced).
REQ-006 btn_b  input  1  lap/clear command, one-cycle pulse (already debounced).
REQ-007 disp  output  24  six BCD digits {m1,m0,s1,s0,c1,c0}, MM:SS.CC; m1 in [23:20], c0 in [3:0].
REQ-008 running  output  1  high in states RUN and LAP.
REQ-009 lap_active  output  1  high in state LAP.
REQ-010 overflow  output  1  one-cycle pulse when the count wraps 59:59.99 -> 00:00.00.

Function
REQ-011 The block SHALL hold a 24-bit BCD count register and a 24-bit lap register, each digit range-limited: c0,c1,s0,m0 in 0-9; s1,m1 in 0-5.
REQ-012 The state machine SHALL have states IDLE, RUN, PAUSE, LAP, with state and all registers updated on the same clock edge.
REQ-013 IDLE: btn_a -> RUN; btn_b ignored.
REQ-014 RUN: btn_a -> PAUSE; btn_b -> LAP, and the lap register captures the count value present in that cycle (before any same-cycle increment).
REQ-015 LAP: btn_a -> PAUSE; btn_b -> RUN.
REQ-016 PAUSE: btn_a -> RUN; btn_b -> IDLE, clearing count and lap registers to zero on the same edge.
REQ-017 When btn_a and btn_b are both high in one cycle, btn_a SHALL take effect and btn_b SHALL be ignored.
REQ-018 A tick SHALL increment the count only when the current (registered) state is RUN or LAP; the decision uses the state before the edge, so a tick coincident with a RUN->PAUSE command is counted and a tick coincident with a PAUSE->RUN command is not.
REQ-019 Increment SHALL be a cascaded BCD ripple: c0 wraps 9->0 and carries into c1, c1 9->0 into s0, s0 9->0 into s1, s1 5->0 into m0, m0 9->0 into m1, m1 5->0 with final carry.
REQ-020 The final carry SHALL wrap the count to 00:00.00 and assert overflow for exactly the cycle after that edge; counting continues.
REQ-021 Increment latency: count and disp reflect a tick one clock after the tick cycle.
REQ-022 disp SHALL show the lap register in LAP and the count register in all other states, selected from the registered state (no added latency).
REQ-023 Ticks arriving in IDLE or PAUSE SHALL be discarded, not queued.

Reset
REQ-024 Asserting rst SHALL at once force state IDLE, count = 0, lap = 0, disp = 24'h000000, running = 0, lap_active = 0, overflow = 0, including mid-count or mid-LAP.
REQ-025 After rst deasserts, the block SHALL ignore no cycles; a btn_a in the first clock edge with rst low SHALL be honoured.

Verification
REQ-026 Reset, btn_a, 250 ticks -> disp = 24'h000250, running = 1.
REQ-027 Preload 59:59.98 via ticks in RUN, 2 more ticks -> disp 24'h595999 then 24'h000000, overflow one cycle high after the second tick.
REQ-028 RUN at 00:01.23, btn_b -> LAP, disp frozen at 24'h000123 over 50 ticks, lap_active = 1; btn_b -> RUN, disp = 24'h000173.
REQ-029 RUN, btn_a and tick same cycle -> PAUSE with that tick counted; further ticks ignored; btn_b -> IDLE, disp = 24'h000000.
REQ-030 btn_a and btn_b together in RUN -> PAUSE, lap unchanged; together in PAUSE -> RUN, count retained.
REQ-031 rst asserted asynchronously mid-LAP between clock edges -> all outputs zero before next edge, state IDLE.

Source files
------------

// File: rtl/stopwatch_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stopwatch_core
//   MM:SS.CC stopwatch with start/stop and lap/clear control. The count is kept
//   directly in BCD so the display needs no conversion.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   tick       in   one-cycle pulse per 1/100 s from the upstream tick timer
//   btn_a      in   start/stop, one-cycle debounced pulse
//   btn_b      in   lap/clear, one-cycle debounced pulse
//   disp       out  {m1,m0,s1,s0,c1,c0} BCD: lap register in LAP, count otherwise
//   running    out  high in RUN and LAP
//   lap_active out  high in LAP
//   overflow   out  one-cycle pulse after the count wraps 59:59.99 -> 00:00.00
//   state_dbg  out  registered FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 LAP)
//
// Interface note: tick, btn_a and btn_b are plain single-cycle strobes with no
// handshake; a strobe is consumed on the edge where it is high and never held.
// When btn_a and btn_b arrive together, btn_a wins and btn_b is dropped.
// -----------------------------------------------------------------------------
module stopwatch_core #(
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_a,
  input  logic        btn_b,
  output logic [23:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic [1:0]  state_dbg
);

  // TICK_HZ only documents the expected tick rate; reject nonsense values.
  if (TICK_HZ < 1) begin : g_bad_tick_hz
    $error("stopwatch_core: TICK_HZ must be positive");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [23:0] count_q;
  logic [23:0] lap_q;
  logic [23:0] count_inc;
  logic        wrap;
  logic        inc;
  logic        cap;
  logic        clr;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. btn_a is tested first so it has priority over btn_b.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (btn_a) state_d = S_RUN;
      end
      S_RUN: begin
        if (btn_a)      state_d = S_PAUSE;
        else if (btn_b) state_d = S_LAP;
      end
      S_LAP: begin
        if (btn_a)      state_d = S_PAUSE;
        else if (btn_b) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (btn_a)      state_d = S_RUN;
        else if (btn_b) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, all decoded from the registered state so disp switches
  // between count and lap on the same edge as the state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    running    = (state_q == S_RUN) || (state_q == S_LAP);
    lap_active = (state_q == S_LAP);
    disp       = (state_q == S_LAP) ? lap_q : count_q;
    state_dbg  = state_q;
  end

  // ---------------------------------------------------------------------------
  // BCD ripple increment. Digit limits: c0,c1,s0,m0 count to 9; s1,m1 to 5.
  // Using >= makes an out-of-range digit recover on its next increment.
  // The carry left over after m1 is the 59:59.99 -> 00:00.00 wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    logic [3:0] limit;
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      digit = count_q[i*4 +: 4];
      limit = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
      if (carry) begin
        if (digit >= limit) begin
          count_inc[i*4 +: 4] = 4'd0;
          carry               = 1'b1;
        end else begin
          count_inc[i*4 +: 4] = digit + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  // Count and lap decisions use the pre-edge state: a tick alongside RUN->PAUSE
  // still counts, a tick alongside PAUSE->RUN does not.
  assign inc = tick && ((state_q == S_RUN) || (state_q == S_LAP));
  assign cap = (state_q == S_RUN)   && btn_b && !btn_a;
  assign clr = (state_q == S_PAUSE) && btn_b && !btn_a;

  // ---------------------------------------------------------------------------
  // Datapath registers. Lap captures the count as it stands before any
  // same-edge increment. clr and inc never coincide (clr only in PAUSE).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 24'h000000;
      lap_q    <= 24'h000000;
      overflow <= 1'b0;
    end else begin
      if (clr) begin
        count_q <= 24'h000000;
      end else if (inc) begin
        count_q <= count_inc;
      end

      if (clr) begin
        lap_q <= 24'h000000;
      end else if (cap) begin
        lap_q <= count_q;
      end

      overflow <= inc && wrap;
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_stopwatch_core
//   Directed bench for stopwatch_core. Each task drives one scenario and checks
//   outputs inline against hand-computed BCD values. Inputs change 1 ns after a
//   rising edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        btn_a;
  logic        btn_b;
  logic [23:0] disp;
  logic        running;
  logic        lap_active;
  logic        overflow;
  logic [1:0]  state_dbg;

  int checks;
  int errors;

  stopwatch_core #(.TICK_HZ(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_a      (btn_a),
    .btn_b      (btn_b),
    .disp       (disp),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock cycle with the given strobes high, then strobes return low.
  task automatic step(input logic a, input logic b, input logic t);
    btn_a = a;
    btn_b = b;
    tick  = t;
    @(posedge clk);
    #1;
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  // Leaves rst low at a falling edge so the next step hits the first edge
  // after reset release.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst   = 1'b1;
    tick  = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    #2;
    checks++;
    if (disp !== 24'h000000) begin
      errors++; $display("FAIL reset_disp: got %h expected %h", disp, 24'h000000);
    end
    checks++;
    if ({running, lap_active, overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected %b", {running, lap_active, overflow}, 3'b000);
    end
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE);
    end
    // Buttons and ticks while reset is held have no effect.
    btn_a = 1'b1;
    tick  = 1'b1;
    @(posedge clk);
    #1;
    btn_a = 1'b0;
    tick  = 1'b0;
    checks++;
    if (state_dbg !== S_IDLE || disp !== 24'h000000) begin
      errors++; $display("FAIL reset_hold: got state %0d disp %h expected state %0d disp %h",
                         state_dbg, disp, S_IDLE, 24'h000000);
    end
  endtask

  task automatic test_count_250();
    do_reset();
    step(1'b1, 1'b0, 1'b0);   // first edge after release must start the watch
    checks++;
    if (state_dbg !== S_RUN || running !== 1'b1) begin
      errors++; $display("FAIL first_edge_start: got state %0d running %b expected state %0d running 1",
                         state_dbg, running, S_RUN);
    end
    ticks(1);
    checks++;
    if (disp !== 24'h000001) begin
      errors++; $display("FAIL tick_latency: got %h expected %h", disp, 24'h000001);
    end
    ticks(249);
    checks++;
    if (disp !== 24'h000250) begin
      errors++; $display("FAIL count_250: got %h expected %h", disp, 24'h000250);
    end
    checks++;
    if (running !== 1'b1 || lap_active !== 1'b0) begin
      errors++; $display("FAIL count_250_flags: got running %b lap %b expected running 1 lap 0",
                         running, lap_active);
    end
  endtask

  task automatic test_minute_carry();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    ticks(5999);
    checks++;
    if (disp !== 24'h005999) begin
      errors++; $display("FAIL count_5999: got %h expected %h", disp, 24'h005999);
    end
    ticks(1);
    checks++;
    if (disp !== 24'h010000) begin
      errors++; $display("FAIL minute_carry: got %h expected %h", disp, 24'h010000);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1'b1, 1'b0, 1'b0);   // RUN
    step(1'b1, 1'b0, 1'b0);   // PAUSE, so the register is quiet while preloaded
    force dut.count_q = 24'h595990;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    checks++;
    if (disp !== 24'h595990) begin
      errors++; $display("FAIL preload: got %h expected %h", disp, 24'h595990);
    end
    step(1'b1, 1'b0, 1'b0);   // RUN
    ticks(8);
    checks++;
    if (disp !== 24'h595998) begin
      errors++; $display("FAIL count_595998: got %h expected %h", disp, 24'h595998);
    end
    ticks(1);
    checks++;
    if (disp !== 24'h595999 || overflow !== 1'b0) begin
      errors++; $display("FAIL count_595999: got %h ovf %b expected %h ovf 0", disp, overflow, 24'h595999);
    end
    ticks(1);
    checks++;
    if (disp !== 24'h000000 || overflow !== 1'b1) begin
      errors++; $display("FAIL wrap: got %h ovf %b expected %h ovf 1", disp, overflow, 24'h000000);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_one_cycle: got %b expected %b", overflow, 1'b0);
    end
    ticks(1);
    checks++;
    if (disp !== 24'h000001 || running !== 1'b1) begin
      errors++; $display("FAIL after_wrap: got %h running %b expected %h running 1", disp, running, 24'h000001);
    end
  endtask

  task automatic test_lap();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    ticks(123);
    checks++;
    if (disp !== 24'h000123) begin
      errors++; $display("FAIL lap_pre: got %h expected %h", disp, 24'h000123);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (state_dbg !== S_LAP || lap_active !== 1'b1 || running !== 1'b1) begin
      errors++; $display("FAIL lap_enter: got state %0d lap %b running %b expected state %0d lap 1 running 1",
                         state_dbg, lap_active, running, S_LAP);
    end
    for (int i = 0; i < 50; i++) begin
      ticks(1);
      checks++;
      if (disp !== 24'h000123) begin
        errors++; $display("FAIL lap_frozen[%0d]: got %h expected %h", i, disp, 24'h000123);
      end
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (disp !== 24'h000173 || lap_active !== 1'b0 || state_dbg !== S_RUN) begin
      errors++; $display("FAIL lap_exit: got %h lap %b state %0d expected %h lap 0 state %0d",
                         disp, lap_active, state_dbg, 24'h000173, S_RUN);
    end
  endtask

  task automatic test_lap_same_tick();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    ticks(5);
    step(1'b0, 1'b1, 1'b1);   // lap captures 5, the same tick takes count to 6
    checks++;
    if (disp !== 24'h000005) begin
      errors++; $display("FAIL lap_capture_pre_inc: got %h expected %h", disp, 24'h000005);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (disp !== 24'h000006) begin
      errors++; $display("FAIL lap_tick_counted: got %h expected %h", disp, 24'h000006);
    end
  endtask

  task automatic test_pause_clear();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    ticks(10);
    step(1'b1, 1'b0, 1'b1);   // stop with a coincident tick: tick is counted
    checks++;
    if (state_dbg !== S_PAUSE || running !== 1'b0 || disp !== 24'h000011) begin
      errors++; $display("FAIL pause_enter: got state %0d running %b disp %h expected state %0d running 0 disp %h",
                         state_dbg, running, disp, S_PAUSE, 24'h000011);
    end
    ticks(5);
    checks++;
    if (disp !== 24'h000011) begin
      errors++; $display("FAIL pause_ticks_dropped: got %h expected %h", disp, 24'h000011);
    end
    step(1'b1, 1'b0, 1'b1);   // resume with a coincident tick: tick is dropped
    checks++;
    if (state_dbg !== S_RUN || disp !== 24'h000011) begin
      errors++; $display("FAIL resume_tick_dropped: got state %0d disp %h expected state %0d disp %h",
                         state_dbg, disp, S_RUN, 24'h000011);
    end
    ticks(1);
    checks++;
    if (disp !== 24'h000012) begin
      errors++; $display("FAIL resume_count: got %h expected %h", disp, 24'h000012);
    end
    step(1'b1, 1'b0, 1'b0);   // PAUSE
    step(1'b0, 1'b1, 1'b0);   // clear to IDLE
    checks++;
    if (state_dbg !== S_IDLE || disp !== 24'h000000 || running !== 1'b0) begin
      errors++; $display("FAIL clear: got state %0d disp %h running %b expected state %0d disp %h running 0",
                         state_dbg, disp, running, S_IDLE, 24'h000000);
    end
    ticks(3);
    step(1'b0, 1'b1, 1'b0);   // btn_b ignored in IDLE
    checks++;
    if (state_dbg !== S_IDLE || disp !== 24'h000000) begin
      errors++; $display("FAIL idle_ignores: got state %0d disp %h expected state %0d disp %h",
                         state_dbg, disp, S_IDLE, 24'h000000);
    end
    step(1'b1, 1'b0, 1'b0);
    ticks(2);
    checks++;
    if (disp !== 24'h000002) begin
      errors++; $display("FAIL restart_from_zero: got %h expected %h", disp, 24'h000002);
    end
  endtask

  task automatic test_both_buttons();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    ticks(20);
    step(1'b0, 1'b1, 1'b0);   // LAP, lap = 20
    step(1'b1, 1'b1, 1'b0);   // LAP: btn_a wins -> PAUSE
    checks++;
    if (state_dbg !== S_PAUSE || disp !== 24'h000020) begin
      errors++; $display("FAIL both_in_lap: got state %0d disp %h expected state %0d disp %h",
                         state_dbg, disp, S_PAUSE, 24'h000020);
    end
    step(1'b1, 1'b1, 1'b0);   // PAUSE: btn_a wins -> RUN, no clear
    checks++;
    if (state_dbg !== S_RUN || disp !== 24'h000020) begin
      errors++; $display("FAIL both_in_pause: got state %0d disp %h expected state %0d disp %h",
                         state_dbg, disp, S_RUN, 24'h000020);
    end
    ticks(7);
    step(1'b1, 1'b1, 1'b0);   // RUN: btn_a wins -> PAUSE, no lap capture
    checks++;
    if (state_dbg !== S_PAUSE || lap_active !== 1'b0 || disp !== 24'h000027) begin
      errors++; $display("FAIL both_in_run: got state %0d lap %b disp %h expected state %0d lap 0 disp %h",
                         state_dbg, lap_active, disp, S_PAUSE, 24'h000027);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    ticks(30);
    step(1'b0, 1'b1, 1'b0);   // LAP showing 30
    ticks(3);
    checks++;
    if (disp !== 24'h000030 || lap_active !== 1'b1) begin
      errors++; $display("FAIL pre_async: got %h lap %b expected %h lap 1", disp, lap_active, 24'h000030);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;               // between edges
    #1;
    checks++;
    if (disp !== 24'h000000) begin
      errors++; $display("FAIL async_disp: got %h expected %h", disp, 24'h000000);
    end
    checks++;
    if ({running, lap_active, overflow} !== 3'b000 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL async_flags: got flags %b state %0d expected flags 000 state %0d",
                         {running, lap_active, overflow}, state_dbg, S_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (state_dbg !== S_RUN || disp !== 24'h000000) begin
      errors++; $display("FAIL post_async_count: got state %0d disp %h expected state %0d disp %h",
                         state_dbg, disp, S_RUN, 24'h000000);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    tick   = 1'b0;
    btn_a  = 1'b0;
    btn_b  = 1'b0;
    test_reset();
    test_count_250();
    test_minute_carry();
    test_overflow();
    test_lap();
    test_lap_same_tick();
    test_pause_clear();
    test_both_buttons();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
